spi_slave_rx_tx: RTL and testbench

SPI slave endpoint that sits on the far side of the `spi_master` link: it receives bytes shifted out on `mosi` and returns bytes on `miso`. SPI mode 0, MSB first, 8-bit frames. It oversamples the master's `sclk` and `ss_n` with the local system clock and presents received bytes and transmit requests through a simple valid/ready-style host interface.

---
 rtl/spi_slave_rx_tx.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave endpoint: oversamples sclk/mosi/ss_n on clk, receives
// MSB-first bytes on mosi and returns buffered bytes on miso.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, mosi, ss_n    SPI pins from the master (sclk idles low)
//   miso, miso_oe       serial data to the master and its pad enable
//   tx_data, tx_load    host write into the one-byte transmit buffer
//   tx_ready            transmit buffer empty
//   rx_data, rx_valid   last received byte and its one-cycle strobe
//   tx_underrun         sticky: a frame started with nothing to send
//   busy                frame in progress
module spi_slave_rx_tx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_MISO   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_d;
    logic                   ss_d;

    logic sclk_s;
    logic mosi_s;
    logic ss_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic [7:0] tx_buf;
    logic       buf_full;
    logic       idle_pend;

    logic start_load;
    logic bnd_load;
    logic sr_load;
    logic shift_en;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    // ss_n chain presets high so reset never looks like a select edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        bnd_load   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt  = SHIFT;
                    start_load = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                end else if (sclk_fall && bit_cnt == 3'd0) begin
                    // falling edge after a full byte: queue the next one
                    bnd_load = 1'b1;
                end
            end
        endcase
    end

    assign sr_load  = start_load | bnd_load;
    assign shift_en = (state == SHIFT) & ~ss_rise;

    assign miso     = tx_sr[7];
    assign miso_oe  = (state == SHIFT);
    assign busy     = (state == SHIFT);
    assign tx_ready = ~buf_full;

    // Counter wraps 7 -> 0 on the 8th rise; abort or idle clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!shift_en) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= {rx_sr[5:0], mosi_s};
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_sr, mosi_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= 8'h00;
        end else if (sr_load) begin
            tx_sr <= buf_full ? tx_buf : IDLE_MISO;
        end else if (shift_en && sclk_fall && bit_cnt != 3'd0) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

    // A load colliding with a shift-register reload still lands:
    // the shift register took the old contents this same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf   <= 8'h00;
            buf_full <= 1'b0;
        end else if (sr_load) begin
            buf_full <= tx_load;
            if (tx_load) begin
                tx_buf <= tx_data;
            end
        end else if (tx_load && !buf_full) begin
            buf_full <= 1'b1;
            tx_buf   <= tx_data;
        end
    end

    // An empty reload at a byte boundary only counts as an underrun
    // once the master actually clocks the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_pend   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (start_load && !buf_full) begin
                tx_underrun <= 1'b1;
            end
            if (shift_en && sclk_rise && bit_cnt == 3'd0 && idle_pend) begin
                tx_underrun <= 1'b1;
            end
            if (bnd_load) begin
                idle_pend <= ~buf_full;
            end else if (!shift_en || sclk_rise) begin
                idle_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Randomized scoreboard bench for spi_slave_rx_tx: a bit-banged SPI
// master drives frames while a monitor checks every rx_valid byte.
module tb_spi_slave_rx_tx;

    localparam logic [7:0] IDLE_B = 8'h00;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    spi_slave_rx_tx #(
        .SYNC_STAGES(2),
        .IDLE_MISO  (IDLE_B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss_n       (ss_n),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    // reference model: one-byte buffer, sticky underrun, last rx byte
    bit         m_full;
    logic [7:0] m_buf;
    bit         m_under;
    logic [7:0] m_last;

    logic [7:0] mo[4];
    bit         ld_en[4];
    logic [7:0] ld_v[4];

    bit rxv_prev;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // scoreboard monitor: every rx_valid pops one expected byte
    always @(negedge clk) begin
        if (!rst_n) begin
            rxv_prev = 1'b0;
        end else begin
            if (rx_valid) begin
                check("rx_valid_width", rxv_prev, 1'b0);
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", 1'b1, 1'b0);
                end else begin
                    check("rx_data", rx_data, exp_q.pop_front());
                end
            end
            rxv_prev = rx_valid;
        end
    end

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_buf   = 8'h00;
        m_under = 1'b0;
        m_last  = 8'h00;
        exp_q.delete();
    endtask

    function automatic logic [7:0] pop_buf();
        if (m_full) begin
            m_full = 1'b0;
            return m_buf;
        end
        return IDLE_B;
    endfunction

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = v;
        end
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic clr_ld();
        for (int k = 0; k < 4; k++) begin
            ld_en[k] = 1'b0;
            ld_v[k]  = 8'h00;
        end
    endtask

    // nb bytes under one select; ab != 0 aborts after ab bits of byte 0
    task automatic run_frame(input int nb, input int ab, input int h);
        logic [7:0] cur;
        logic [7:0] rd;
        bit         more;
        ss_n = 1'b0;
        wt(6);
        if (!m_full) m_under = 1'b1;
        cur = pop_buf();
        for (int b = 0; b < nb; b++) begin
            rd = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (ab != 0 && i == ab) break;
                mosi = mo[b][7-i];
                wt(h);
                rd = {rd[6:0], miso};
                if (i == 1) begin
                    check("tx_ready_mid", tx_ready, !m_full);
                    check("busy_mid", busy, 1'b1);
                    check("miso_oe_mid", miso_oe, 1'b1);
                end
                sclk = 1'b1;
                if (i == 7) begin
                    exp_q.push_back(mo[b]);
                    m_last = mo[b];
                end
                if (i == 0 && ld_en[b]) begin
                    do_load(ld_v[b]);
                    wt(h - 2);
                end else begin
                    wt(h);
                end
                sclk = 1'b0;
            end
            if (ab != 0) break;
            check("miso_byte", rd, cur);
            more = (b < nb - 1);
            if (more && !m_full) m_under = 1'b1;
            cur = pop_buf();
        end
        wt(h);
        ss_n = 1'b1;
        if (ab != 0) begin
            wt(4);
            check("abort_busy", busy, 1'b0);
            check("abort_miso_oe", miso_oe, 1'b0);
            wt(4);
        end else begin
            wt(8);
        end
        check("rx_pending", exp_q.size(), 0);
        check("rx_data_hold", rx_data, m_last);
        check("tx_underrun", tx_underrun, m_under);
        check("tx_ready_idle", tx_ready, !m_full);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, miso, 1'b0);
        check({tag, "_miso_oe"}, miso_oe, 1'b0);
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_tx_ready"}, tx_ready, 1'b1);
        check({tag, "_tx_underrun"}, tx_underrun, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int nb;
        int ab;
        int h;
        rst_n   = 1'b0;
        sclk    = 1'b0;
        mosi    = 1'b0;
        ss_n    = 1'b1;
        tx_data = 8'h00;
        tx_load = 1'b0;
        model_reset();
        clr_ld();
        wt(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        wt(4);

        // single frame
        do_load(8'hA5);
        check("tx_ready_loaded", tx_ready, 1'b0);
        mo[0] = 8'h3C;
        run_frame(1, 0, 5);

        // underrun
        mo[0] = 8'hFF;
        run_frame(1, 0, 5);

        // back-to-back, second byte loaded during the first
        do_load(8'h81);
        mo[0] = 8'h12;
        mo[1] = 8'h34;
        ld_en[0] = 1'b1;
        ld_v[0]  = 8'h7E;
        run_frame(2, 0, 6);
        clr_ld();

        // abort after 5 bits, then a full frame
        mo[0] = 8'h96;
        run_frame(1, 5, 5);
        mo[0] = 8'hC3;
        run_frame(1, 0, 5);

        // write while full is ignored
        do_load(8'h11);
        do_load(8'h22);
        check("tx_ready_full", tx_ready, 1'b0);
        mo[0] = 8'h0F;
        run_frame(1, 0, 5);

        // reset mid-frame
        do_load(8'h99);
        ss_n = 1'b0;
        wt(6);
        for (int i = 0; i < 3; i++) begin
            mosi = i[0];
            wt(5);
            sclk = 1'b1;
            if (i == 0) begin
                do_load(8'h77);
                wt(3);
            end else begin
                wt(5);
            end
            sclk = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sclk = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        model_reset();
        wt(3);
        rst_n = 1'b1;
        wt(4);
        do_load(8'h3E);
        mo[0] = 8'h5A;
        run_frame(1, 0, 5);

        // randomized transactions
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                model_reset();
                wt(2);
                rst_n = 1'b1;
                wt(3);
                check("rand_rst_underrun", tx_underrun, 1'b0);
            end
            nb = $urandom_range(1, 3);
            h  = $urandom_range(5, 7);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 4; k++) begin
                mo[k]    = 8'($urandom);
                ld_en[k] = ($urandom_range(0, 1) == 1);
                ld_v[k]  = 8'($urandom);
            end
            if ($urandom_range(0, 2) != 0) do_load(8'($urandom));
            run_frame(nb, ab, h);
            wt($urandom_range(1, 5));
        end
        clr_ld();

        wt(10);
        check("rx_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
